// File: rtl/aes_result_unpacker.sv
// aes_result_unpacker
//   Output end of the AES round pipeline. Completed 130-bit packets
//   {valid, data[127:0], en_de} are buffered in a small FIFO and each
//   128-bit result is returned to the host as four 32-bit words,
//   most-significant word first, over a valid/ready handshake.
//   The round pipeline cannot be stalled, so fill level, almost-full and a
//   sticky overflow flag are exported for the issue logic.
//
// Ports
//   clk           pipeline clock
//   rst           synchronous active-high reset
//   pkt_in        {valid[129], data[128:1], en_de[0]} from the last round stage
//   out_word      result word
//   out_valid     out_word valid
//   out_ready     host accepts the current word
//   out_last      marks the 4th word of a block
//   out_en_de     en_de of the block being sent (1 = decrypt)
//   fifo_count    packets held, including the one being sent
//   almost_full   fifo_count >= AF_LEVEL
//   overflow      sticky: a valid packet was dropped
//   clr_overflow  clears overflow (a same-cycle drop wins)
module aes_result_unpacker #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [129:0]             pkt_in,
  output logic [31:0]              out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_en_de,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [128:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [1:0]     widx;
  logic [128:0]   head;
  logic           pkt_valid;
  logic           xfer;
  logic           pop;
  logic           full;
  logic           push;
  logic           drop;
  logic [CW-1:0]  count_nxt;

  // Handshake and FIFO control. A final-word pop frees the slot for a
  // same-cycle enqueue, so a full FIFO only drops when nothing is popping.
  always_comb begin
    pkt_valid = pkt_in[129];
    xfer      = (state == SEND) && out_ready;
    pop       = xfer && (widx == 2'd3);
    full      = (fifo_count == CW'(DEPTH));
    push      = pkt_valid && (!full || pop);
    drop      = pkt_valid && full && !pop;

    count_nxt = fifo_count;
    if (push && !pop) begin
      count_nxt = fifo_count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = fifo_count - CW'(1);
    end
  end

  // Next-state: a packet written into an empty FIFO is presented on the
  // very next cycle; after the final pop we stay in SEND if anything is left.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = SEND;
      SEND:    if (count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      widx       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (xfer) widx   <= widx + 2'd1;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; contents are only observed through the head
  // pointer while in SEND, and outputs are gated to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_in[128:0];
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_valid = (state == SEND);
    out_word  = '0;
    out_last  = 1'b0;
    out_en_de = 1'b0;
    if (out_valid) begin
      out_last  = (widx == 2'd3);
      out_en_de = head[0];
      case (widx)
        2'd0:    out_word = head[128:97];
        2'd1:    out_word = head[96:65];
        2'd2:    out_word = head[64:33];
        default: out_word = head[32:1];
      endcase
    end
  end

  assign almost_full = (fifo_count >= CW'(AF_LEVEL));

endmodule

// File: doc/aes_result_unpacker.md
Name: aes_result_unpacker

Overview:
- Output end of the AES round pipeline; consumes the 130-bit out_packet_t stream emitted by the last round stage.
- Buffers completed blocks in a small FIFO and returns each 128-bit result to the host as four 32-bit words over a valid/ready interface.
- The pipeline has no backpressure, so the block reports fill level and almost-full for the issue logic, plus a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO depth in 130-bit packets; power of two, >= 2.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- pkt_in  in  130 (out_packet_t)  {valid[129], data[128:1], en_de[0]} from the final round stage
- out_word  out  32  result word
- out_valid  out  1  out_word valid
- out_ready  in  1  host accepts word
- out_last  out  1  marks the 4th word of a block
- out_en_de  out  1  en_de of the block being sent (1 = decrypt)
- fifo_count  out  $clog2(DEPTH)+1  packets held, including the one being sent
- almost_full  out  1  fifo_count >= AF_LEVEL
- overflow  out  1  sticky: a valid packet was dropped
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset, synchronous on rst=1 at posedge clk: FIFO empty, word index 0, out_valid=0, out_last=0, out_word=0, out_en_de=0, fifo_count=0, almost_full=0, overflow=0. rst mid-block discards the partial block and all queued packets.
- Enqueue: on each posedge where pkt_in[129]=1, the {data, en_de} pair is written to the tail. pkt_in[129]=0 is ignored whatever the other bits hold, including the pipeline idle filler 130'hdeadbeef.
- Dequeue FSM states:
  - IDLE: FIFO empty.
  - SEND: head packet presented, word index w=0..3.
- out_valid = (state==SEND).
- Word mapping: out_word = data[127-32w -: 32], so data[127:96] goes first (AES byte order). out_last = (w==3). out_en_de = head en_de, constant across all 4 words.
- Transfer: a word moves on posedge with out_valid && out_ready.
  - On transfer with w<3: w increments.
  - On transfer with w==3: head pops and w returns to 0.
  - If the FIFO is still non-empty after the pop, the next block starts with no bubble. Otherwise the FSM goes to IDLE.
- Stability: while out_valid && !out_ready, out_word, out_last and out_en_de hold stable.
- Latency: a packet arriving at edge N into an empty FIFO gives out_valid=1 with word0 after edge N (visible in cycle N+1). Minimum drain is 4 cycles per block with out_ready held high.
- Full with enqueue and final-word pop in the same cycle: the pop frees the slot and the enqueue is accepted; fifo_count is unchanged.
- Full with enqueue and no final-word pop: the packet is dropped, overflow is set to 1, and FIFO contents and fifo_count are unchanged.
- overflow: cleared by clr_overflow. If a set and a clear occur in the same cycle, the set wins.
- fifo_count: registered, +1 per enqueue, -1 per pop, both in the same cycle gives no change. almost_full is derived combinationally from the registered count.
- Pointers: wrap modulo DEPTH. Full/empty are distinguished via count, not pointer equality.

Test Plan:
- Single block: after reset, pkt_in = {1, 128'h00112233_44556677_8899aabb_ccddeeff, 0} for 1 cycle, out_ready=1 -> out_valid next cycle; words 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles; out_last only on the 4th; out_en_de=0; fifo_count 1 then 0.
- Filler ignored: pkt_in = 130'hdeadbeef for 20 cycles -> out_valid stays 0, fifo_count=0, overflow=0.
- Backpressure: one decrypt block, out_ready toggling 1,0,0,1,1,0,1 -> each word held stable while stalled; exactly 4 transfers in order; out_en_de=1 throughout.
- Overflow: out_ready=0, 5 valid packets on consecutive cycles (DEPTH=4) -> almost_full from count 3; 5th packet dropped, overflow=1, count=4; release out_ready -> the first 4 blocks are delivered intact, 16 words back-to-back with no bubbles; clr_overflow -> overflow=0.
- Simultaneous enqueue and pop at full: FIFO full, out_ready=1, valid packet arrives in the same cycle as word3 of the head block -> packet accepted, overflow stays 0, count stays 4, the new block appears last.
- Reset mid-block: assert rst after word1 of a block with 2 queued -> next cycle out_valid=0, fifo_count=0; a fresh block afterwards starts at word0.
